// File: rtl/paralelo_serial_tx.sv
// paralelo_serial_tx
//   Transmit-side serializer for the PHY link. Bytes arrive on a valid/ready
//   handshake and leave MSB-first on a 1-bit line, one bit per clk_32f cycle.
//   After reset a preamble of SYNC_COUNT COM symbols is sent so the far-end
//   receiver can byte-align. After that, COM is sent as idle fill on any
//   symbol boundary where no byte is offered.
//
// Ports
//   clk_32f    in   bit clock, one serial bit per cycle
//   reset      in   synchronous reset, active-high
//   data_in    in   [7:0] byte to transmit
//   valid_in   in   data_in holds a byte to send
//   ready_out  out  data_in is taken at this edge if valid_in=1
//   data_out   out  serial stream, MSB first (shift_reg[7])
//   idle_out   out  high while the symbol on data_out is an inserted COM
//   sync_done  out  preamble complete; sticky until reset
//   state_dbg  out  FSM state (0 = SYNC, 1 = ACTIVE)
//
// Handshake: a byte is consumed on a rising edge of clk_32f where
//   ready_out && valid_in. ready_out is a function of registers only and
//   never depends on valid_in. Upstream holds data_in/valid_in stable until
//   that edge.

module paralelo_serial_tx #(
   parameter logic [7:0] COM        = 8'hBC,
   parameter int         SYNC_COUNT = 4
) (
   input  logic       clk_32f,
   input  logic       reset,
   input  logic [7:0] data_in,
   input  logic       valid_in,
   output logic       ready_out,
   output logic       data_out,
   output logic       idle_out,
   output logic       sync_done,
   output logic       state_dbg
);

   localparam logic [3:0] SYNC_CNT = 4'(SYNC_COUNT);

   typedef enum logic {
      SYNC   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   state_t     state;
   state_t     state_next;
   logic [7:0] shift_reg;
   logic [2:0] bit_cnt;
   logic [3:0] sym_cnt;
   logic       load;

   // Symbol boundary: the last bit of the current symbol is on the line.
   assign load      = (bit_cnt == 3'd7);
   assign data_out  = shift_reg[7];
   assign state_dbg = state;

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_32f) begin
      if (reset) begin
         state <= SYNC;
      end else begin
         state <= state_next;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next state. The first handshake boundary ends the preamble,
   // whether or not a byte is actually offered there.
   // ---------------------------------------------------------------------
   always_comb begin
      state_next = state;
      if (load && ready_out) begin
         state_next = ACTIVE;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: outputs. In SYNC the handshake opens only once the last preamble
   // COM has been loaded and is about to finish.
   // ---------------------------------------------------------------------
   always_comb begin
      ready_out = 1'b0;
      if (load && (state == ACTIVE || sym_cnt == SYNC_CNT)) begin
         ready_out = 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // Datapath: bit counter, shifter, preamble counter, status flags.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_32f) begin
      if (reset) begin
         shift_reg <= 8'h00;
         bit_cnt   <= 3'd7;
         sym_cnt   <= 4'd0;
         idle_out  <= 1'b0;
         sync_done <= 1'b0;
      end else begin
         bit_cnt <= bit_cnt + 3'd1;
         if (load) begin
            if (ready_out) begin
               sync_done <= 1'b1;
               if (valid_in) begin
                  shift_reg <= data_in;
                  idle_out  <= 1'b0;
               end else begin
                  shift_reg <= COM;
                  idle_out  <= 1'b1;
               end
            end else begin
               // Only reachable in SYNC with sym_cnt below SYNC_COUNT:
               // send another preamble COM and ignore data_in.
               shift_reg <= COM;
               sym_cnt   <= sym_cnt + 4'd1;
               idle_out  <= 1'b1;
            end
         end else begin
            shift_reg <= {shift_reg[6:0], 1'b0};
         end
      end
   end

endmodule
